// File: rtl/pwm_deadtime_bank_if.sv
// Control and gate-drive bundle for the dead-time PWM bank.
// The master drives run/duty/mode and observes the gate drives.
interface pwm_deadtime_bank_if #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned DUTY_WIDTH = 10
);
  logic                           enable;
  logic [CHANNELS*DUTY_WIDTH-1:0] duty;
  logic [CHANNELS*2-1:0]          mode;
  logic [CHANNELS-1:0]            pwm_high;
  logic [CHANNELS-1:0]            pwm_low;
  logic                           period_start;

  modport master (
    output enable, duty, mode,
    input  pwm_high, pwm_low, period_start
  );

  modport slave (
    input  enable, duty, mode,
    output pwm_high, pwm_low, period_start
  );
endinterface

// File: rtl/pwm_deadtime_bank.sv
// Bank of half-bridge PWM channels sharing one period counter.
// Each channel has double-buffered duty and a dead-time enforcing gate FSM.
module pwm_deadtime_bank #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned DUTY_WIDTH = 10,
  parameter int unsigned PERIOD     = 1000,
  parameter int unsigned DEAD_TIME  = 4
) (
  input logic                clock,
  input logic                reset_n,
  pwm_deadtime_bank_if.slave bus
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam int unsigned SW = DUTY_WIDTH + 1;
  localparam int unsigned DW = $clog2(DEAD_TIME + 1);

  typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_HI, ST_LO} state_t;
  typedef enum logic [1:0] {TG_NONE, TG_HI, TG_LO} target_t;

  logic [CW-1:0]   count_q;
  logic [SW-1:0]   shadow_q [CHANNELS];
  logic [SW-1:0]   duty_sat [CHANNELS];
  target_t         target   [CHANNELS];
  state_t          state_q  [CHANNELS];
  state_t          state_d  [CHANNELS];
  logic [DW-1:0]   dead_q   [CHANNELS];
  logic [DW-1:0]   dead_d   [CHANNELS];
  logic [CHANNELS-1:0] high_q;
  logic [CHANNELS-1:0] low_q;

  logic period_end;
  assign period_end = (count_q == CW'(PERIOD - 1));

  // Requested duty clamped at PERIOD so anything larger reads as 100 %.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      duty_sat[k] = SW'(bus.duty[k*DUTY_WIDTH +: DUTY_WIDTH]);
      if (duty_sat[k] > SW'(PERIOD)) duty_sat[k] = SW'(PERIOD);
    end
  end

  // Shared counter and shadow duties; shadows follow duty while stopped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      for (int k = 0; k < CHANNELS; k++) shadow_q[k] <= '0;
    end else begin
      if (!bus.enable || period_end) count_q <= '0;
      else                           count_q <= count_q + CW'(1);
      if (!bus.enable || period_end) begin
        for (int k = 0; k < CHANNELS; k++) shadow_q[k] <= duty_sat[k];
      end
    end
  end

  // Per-channel desired gate side for this cycle.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      target[k] = TG_NONE;
      if (bus.enable) begin
        unique case (bus.mode[2*k +: 2])
          2'b01:   target[k] = (SW'(count_q) < shadow_q[k]) ? TG_HI : TG_LO;
          2'b10:   target[k] = TG_LO;
          default: target[k] = TG_NONE;
        endcase
      end
    end
  end

  // Gate FSM next state: a side change always passes through a full DEAD
  // interval, and the dead count is not restarted if the target flips.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k] = state_q[k];
      dead_d[k]  = dead_q[k];
      if (target[k] == TG_NONE) begin
        state_d[k] = ST_OFF;
        dead_d[k]  = '0;
      end else begin
        unique case (state_q[k])
          ST_DEAD: begin
            if (dead_q[k] == '0) state_d[k] = (target[k] == TG_HI) ? ST_HI : ST_LO;
            else                 dead_d[k]  = dead_q[k] - DW'(1);
          end
          default: begin
            if ((target[k] == TG_HI && state_q[k] != ST_HI) ||
                (target[k] == TG_LO && state_q[k] != ST_LO)) begin
              state_d[k] = ST_DEAD;
              dead_d[k]  = DW'(DEAD_TIME - 1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= ST_OFF;
        dead_q[k]  <= '0;
      end
      high_q <= '0;
      low_q  <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        dead_q[k]  <= dead_d[k];
        high_q[k]  <= (state_d[k] == ST_HI);
        low_q[k]   <= (state_d[k] == ST_LO);
      end
    end
  end

  assign bus.pwm_high     = high_q;
  assign bus.pwm_low      = low_q;
  assign bus.period_start = reset_n & bus.enable & (count_q == '0);

endmodule
